// File: rtl/display_pkg.sv
// display_pkg: shared screen defaults and flusher FSM state encoding.
package display_pkg;
  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;
  localparam logic [5:0] BG_COLOUR_DEF = 6'b000000;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y scan position with end-of-row wrap, stepping only when told to.
module raster_counter import display_pkg::*; #(
  parameter int W = SCR_W_DEF,
  parameter int H = SCR_H_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last
);
  localparam logic [7:0] X_MAX = 8'(W - 1);
  localparam logic [7:0] Y_MAX = 8'(H - 1);
  logic [7:0] x_q, x_d, y_q, y_d;
  logic       x_end;
  assign x_end = x_q == X_MAX;
  assign last = x_end && y_q == Y_MAX;
  assign x = x_q;
  assign y = y_q;
  always_comb begin
    x_d = clear ? 8'd0 : !step ? x_q : x_end ? 8'd0 : x_q + 8'd1;
    y_d = clear ? 8'd0 : !(step && x_end) ? y_q : y_q == Y_MAX ? 8'd0 : y_q + 8'd1;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q <= 8'd0;
      y_q <= 8'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/screen_flusher.sv
// screen_flusher: scans every pixel once, plotting glyph or background colour; FLUSH_SKIP_BG_EN plots glyph pixels only.
module screen_flusher import display_pkg::*; #(
  parameter int         SCR_W     = SCR_W_DEF,
  parameter int         SCR_H     = SCR_H_DEF,
  parameter logic [5:0] BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       hold,
  output logic [7:0] flush_x,
  output logic [7:0] flush_y,
  input  logic       glyph_enable,
  input  logic [5:0] glyph_colour,
  output logic       plot,
  output logic [7:0] plot_x,
  output logic [7:0] plot_y,
  output logic [5:0] plot_colour,
  output logic       busy,
  output logic       done
);
  state_t     state_q, state_d;
  logic       issue, last;
  logic       plot_q, plot_d;
  logic [7:0] plot_x_q, plot_x_d, plot_y_q, plot_y_d;
  logic [5:0] plot_colour_q, plot_colour_d;
  raster_counter #(.W(SCR_W), .H(SCR_H)) u_raster (
    .clock (clock),
    .resetn(resetn),
    .clear (state_q == IDLE),
    .step  (issue),
    .x     (flush_x),
    .y     (flush_y),
    .last  (last)
  );
  // A pixel is issued on every unheld SCAN cycle; the decoders answer in that same cycle.
  assign issue = state_q == SCAN && !hold;
  always_comb begin
    state_d = state_q == IDLE  ? (start ? SCAN : IDLE) :
              state_q == SCAN  ? (issue && last ? DRAIN : SCAN) :
              state_q == DRAIN ? DONE : IDLE;
`ifdef FLUSH_SKIP_BG_EN
    plot_d = issue && glyph_enable;
`else
    plot_d = issue;
`endif
    plot_x_d      = issue ? flush_x : plot_x_q;
    plot_y_d      = issue ? flush_y : plot_y_q;
    plot_colour_d = issue ? (glyph_enable ? glyph_colour : BG_COLOUR) : plot_colour_q;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      plot_q        <= 1'b0;
      plot_x_q      <= 8'd0;
      plot_y_q      <= 8'd0;
      plot_colour_q <= 6'd0;
    end else begin
      state_q       <= state_d;
      plot_q        <= plot_d;
      plot_x_q      <= plot_x_d;
      plot_y_q      <= plot_y_d;
      plot_colour_q <= plot_colour_d;
    end
  end
  assign plot        = plot_q;
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_colour = plot_colour_q;
  assign busy        = state_q == SCAN || state_q == DRAIN;
  assign done        = state_q == DONE;
endmodule

// File: tb/tb_screen_flusher.sv
// tb_screen_flusher: scoreboard bench; expected pixels queued per frame, monitor pops on each plot.
module tb_screen_flusher;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;
`ifdef FLUSH_SKIP_BG_EN
  localparam int PLOTS_A = 0;
  localparam int PLOTS_B = 5;
  localparam int PLOTS_C = 0;
`else
  localparam int PLOTS_A = N;
  localparam int PLOTS_B = N;
  localparam int PLOTS_C = 60 * W;
`endif
  logic clock = 0, resetn = 0, start = 0, hold = 0, pat = 0;
  logic glyph_enable;
  logic [5:0] glyph_colour, plot_colour;
  logic [7:0] flush_x, flush_y, plot_x, plot_y;
  logic plot, busy, done;
  int n_cmp = 0, n_bad = 0, n_plot = 0, n_done = 0, cyc = 0, done_cyc = 0, s_cyc = 0;
  logic [21:0] exp_q[$];
  logic [15:0] last_xy = 16'd0;

  screen_flusher dut (
    .clock(clock), .resetn(resetn), .start(start), .hold(hold),
    .flush_x(flush_x), .flush_y(flush_y),
    .glyph_enable(glyph_enable), .glyph_colour(glyph_colour),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Glyph decoder stand-in: white strip at (2..6,0); off-glyph colour is junk that must not leak.
  always_comb begin
    glyph_enable = pat && flush_y == 8'd0 && flush_x >= 8'd2 && flush_x <= 8'd6;
    glyph_colour = glyph_enable ? 6'h3f : 6'h2a;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (plot) begin
      n_plot++;
      last_xy = {plot_x, plot_y};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_plot: got (%0d,%0d) expected none", plot_x, plot_y);
      end else chk("pixel", {plot_x, plot_y, plot_colour}, exp_q.pop_front());
    end
  end

  task automatic push_frame(input logic p, input int rows);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < W; x++) begin
        logic en;
        en = p && y == 0 && x >= 2 && x <= 6;
`ifdef FLUSH_SKIP_BG_EN
        if (en) exp_q.push_back({8'(x), 8'(y), 6'h3f});
`else
        exp_q.push_back({8'(x), 8'(y), en ? 6'h3f : 6'h00});
`endif
      end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1;
    s_cyc = cyc;
    @(negedge clock);
    start = 0;
  endtask

  task automatic wait_xy(input int x, input int y);
    for (int i = 0; i < 40000; i++) begin
      @(negedge clock);
      if (flush_x == 8'(x) && flush_y == 8'(y)) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_xy timeout: got (%0d,%0d) expected (%0d,%0d)", flush_x, flush_y, x, y);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40000; i++) begin
      @(negedge clock);
      if (n_done > 0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL done_timeout: got no done expected one");
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_coords"}, {flush_x, flush_y, plot_x, plot_y}, 64'd0);
    chk({tag, "_ctrl"}, {plot, plot_colour, busy, done}, 64'd0);
  endtask

  task automatic post_frame(input int plots);
    repeat (5) @(negedge clock);
    chk("done_count", 64'(n_done), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("queue_left", 64'(exp_q.size()), 64'd0);
    chk("plot_count", 64'(n_plot), 64'(plots));
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    resetn = 1;
    // Plain background frame.
    n_plot = 0;
    n_done = 0;
    push_frame(0, H);
    pulse_start();
    chk("busy_scan", 64'(busy), 64'd1);
    wait_done();
    chk("frame_len", 64'(done_cyc - s_cyc), 64'(N + 2));
    post_frame(PLOTS_A);
`ifndef FLUSH_SKIP_BG_EN
    chk("last_pixel", 64'(last_xy), {48'd0, 8'd159, 8'd119});
`endif
    // Glyph strip, 3-cycle hold at (10,0), ignored restart at (50,0).
    n_plot = 0;
    n_done = 0;
    pat = 1;
    push_frame(1, H);
    pulse_start();
    wait_xy(10, 0);
    hold = 1;
    repeat (3) begin
      @(negedge clock);
      chk("hold_no_plot", 64'(plot), 64'd0);
      chk("hold_frozen", {flush_x, flush_y}, {48'd0, 8'd10, 8'd0});
    end
    hold = 0;
    wait_xy(50, 0);
    start = 1;
    @(negedge clock);
    start = 0;
    chk("restart_ignored", {flush_x, flush_y}, {48'd0, 8'd51, 8'd0});
    wait_done();
    chk("frame_len_hold", 64'(done_cyc - s_cyc), 64'(N + 5));
    post_frame(PLOTS_B);
    pat = 0;
    // Reset mid-frame at row 60.
    n_plot = 0;
    n_done = 0;
    push_frame(0, 60);
    pulse_start();
    wait_xy(0, 60);
    resetn = 0;
    @(negedge clock);
    check_idle_outputs("abort");
    resetn = 1;
    repeat (20) @(negedge clock);
    chk("abort_no_done", 64'(n_done), 64'd0);
    chk("abort_plots", 64'(n_plot), 64'(PLOTS_C));
    chk("abort_queue", 64'(exp_q.size()), 64'd0);
    chk("abort_idle", {busy, plot}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
